// File: rtl/msg_pkg.sv
// Shared definitions for the serial message link (transmitter and four-ones receiver).
package msg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    SEP   = 3'd2,
    DATA  = 3'd3,
    STUFF = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int PREAMBLE_LEN = 4;
  localparam int MAX_RUN      = 3;

endpackage

// File: rtl/gerador_mensagem.sv
// Serial frame transmitter: 1111, 0, bit-stuffed payload MSB first, 0. First bit one cycle after start.
// No backpressure: start is only honoured in IDLE or STOP; a frame always runs to completion.
module gerador_mensagem
  import msg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic         out_bit,
  output logic         busy,
  output logic         done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state, state_nx;
  logic [N-1:0]  shreg, shreg_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [1:0]    run, run_nx;
  logic [1:0]    pcnt, pcnt_nx;
  logic          out_nx, busy_nx, done_nx;

  // The state names the bit currently on the line; each transition computes the next bit.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    run_nx   = run;
    pcnt_nx  = pcnt;
    out_nx   = 1'b0;
    busy_nx  = 1'b1;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          state_nx = PRE;
          shreg_nx = data_in;
          run_nx   = 2'd0;
          pcnt_nx  = 2'd0;
          out_nx   = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      PRE: begin
        if (pcnt == 2'(PREAMBLE_LEN - 1)) begin
          state_nx = SEP;
        end else begin
          pcnt_nx = pcnt + 2'd1;
          out_nx  = 1'b1;
        end
      end
      SEP: begin
        state_nx = DATA;
        idx_nx   = '0;
        out_nx   = shreg[N-1];
        shreg_nx = shreg << 1;
        run_nx   = shreg[N-1] ? run + 2'd1 : 2'd0;
      end
      DATA, STUFF: begin
        // A third consecutive 1 forces a stuff 0, even after the last payload bit.
        if (state == DATA && run == 2'(MAX_RUN)) begin
          state_nx = STUFF;
          run_nx   = 2'd0;
        end else if (idx == LAST_IDX) begin
          state_nx = STOP;
          done_nx  = 1'b1;
        end else begin
          state_nx = DATA;
          idx_nx   = idx + 1'b1;
          out_nx   = shreg[N-1];
          shreg_nx = shreg << 1;
          run_nx   = shreg[N-1] ? run + 2'd1 : 2'd0;
        end
      end
      STOP: begin
        if (start) begin
          state_nx = PRE;
          shreg_nx = data_in;
          run_nx   = 2'd0;
          pcnt_nx  = 2'd0;
          out_nx   = 1'b1;
        end else begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      run     <= 2'd0;
      pcnt    <= 2'd0;
      out_bit <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      idx     <= idx_nx;
      run     <= run_nx;
      pcnt    <= pcnt_nx;
      out_bit <= out_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_gerador_mensagem.sv
// Directed frame table, multi-cycle corner sequences and a random loopback into a four-ones detector.
module tb_gerador_mensagem;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         out_bit, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  gerador_mensagem #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .out_bit (out_bit),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Loopback receiver: one-cycle pulse registered after the fourth consecutive 1.
  logic [2:0] rrun;
  logic       det;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rrun <= 3'd0;
      det  <= 1'b0;
    end else begin
      det  <= out_bit && (rrun == 3'd3);
      rrun <= out_bit ? ((rrun == 3'd7) ? 3'd7 : rrun + 3'd1) : 3'd0;
    end
  end

  typedef struct {
    logic [7:0]  d;
    logic [31:0] bits;
    int          len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame builder: preamble, separator, payload with a 0 after every third 1, stop.
  function automatic void model(input logic [7:0] d, output logic [31:0] bits, output int len);
    int r;
    bits = 32'b11110;
    len  = 5;
    r    = 0;
    for (int i = 7; i >= 0; i--) begin
      bits = {bits[30:0], d[i]};
      len++;
      r = d[i] ? r + 1 : 0;
      if (r == 3) begin
        bits = {bits[30:0], 1'b0};
        len++;
        r = 0;
      end
    end
    bits = {bits[30:0], 1'b0};
    len++;
  endfunction

  task automatic kick(input logic [7:0] d);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Samples one frame at negedges starting at its first bit; optionally chains the next frame from STOP.
  task automatic capture(input bit noise, input bit chain, input logic [7:0] chain_d,
                         output logic [31:0] bits, output int len, output int donepos,
                         output int ndone, output int busycnt, output int ndet, output int detpos);
    bit was_done;
    bits = '0; len = 0; donepos = -1; ndone = 0; busycnt = 0; ndet = 0; detpos = -1;
    for (int c = 0; c < 24; c++) begin
      if (!busy) break;
      busycnt++;
      bits = {bits[30:0], out_bit};
      if (det) begin ndet++; detpos = len; end
      was_done = done;
      if (done) begin ndone++; donepos = len; end
      len++;
      if (was_done && chain) begin
        start = 1'b1; data_in = chain_d;
      end else if (noise && !was_done) begin
        start = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (was_done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] eb, input int el,
                             input bit noise, input bit chain, input logic [7:0] chain_d);
    logic [31:0] bits;
    int len, dp, nd, bc, ndet, detpos;
    capture(noise, chain, chain_d, bits, len, dp, nd, bc, ndet, detpos);
    chk({tag, "_bits"}, bits, eb);
    chk({tag, "_len"}, 32'(len), 32'(el));
    chk({tag, "_busycycles"}, 32'(bc), 32'(el));
    chk({tag, "_donecount"}, 32'(nd), 32'd1);
    chk({tag, "_donepos"}, 32'(dp), 32'(el - 1));
    chk({tag, "_detcount"}, 32'(ndet), 32'd1);
    chk({tag, "_detpos"}, 32'(detpos), 32'd4);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] mb;
    int          ml;
    logic [7:0]  cur, nxt;
    bit          chained;

    vecs[0] = '{8'h00, 32'b11110000000000,   14};
    vecs[1] = '{8'hFF, 32'b1111011101110110, 16};
    vecs[2] = '{8'hE7, 32'b1111011100011100, 16};
    vecs[3] = '{8'hA5, 32'b11110101001010,   14};
    vecs[4] = '{8'h77, 32'b1111001110011100, 16};
    vecs[5] = '{8'h0F, 32'b111100000111010,  15};

    // Reset state
    #2;
    chk("reset_out", 32'(out_bit), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_out", 32'(out_bit), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      kick(vecs[i].d);
      check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].len, 1'b0, 1'b0, 8'h00);
      chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_idle_out", i), 32'(out_bit), 32'd0);
      @(negedge clk);
    end

    // Mid-frame start noise ignored, then start in STOP chains an A5 frame with no gap
    kick(8'h00);
    check_frame("noise", vecs[0].bits, 14, 1'b1, 1'b1, 8'hA5);
    chk("chain_first_bit", 32'(out_bit), 32'd1);
    chk("chain_busy", 32'(busy), 32'd1);
    check_frame("chainA5", vecs[3].bits, 14, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Asynchronous reset during DATA
    kick(8'hFF);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_out", 32'(out_bit), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_out", 32'(out_bit), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    kick(8'h00);
    check_frame("post_reset", vecs[0].bits, 14, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Random loopback, mixing idle gaps and back-to-back frames
    chained = 1'b0;
    cur = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      bit ch;
      nxt = 8'($urandom);
      ch  = (i < 199) && ($urandom_range(0, 1) == 1);
      if (!chained) kick(cur);
      model(cur, mb, ml);
      check_frame($sformatf("rnd%0d", i), mb, ml, 1'b0, ch, nxt);
      chained = ch;
      cur = nxt;
      if (!ch) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
